// File: rtl/pipelined_control_unit_if.sv
// Bus between the ID stage and the control unit: IF/ID opcode and hazard controls in,
// registered EX/MEM/WB control, stall and performance counters out.
interface pipelined_control_unit_if #(
   parameter int OPCODE_W  = 6,
   parameter int EXE_CMD_W = 4,
   parameter int CNT_W     = 32
);
   logic [OPCODE_W-1:0]  opcode_in;
   logic                 in_valid;
   logic                 hazard_stall;
   logic                 flush;
   logic [EXE_CMD_W-1:0] exe_cmd;
   logic                 mem_read;
   logic                 mem_write;
   logic                 wb_en;
   logic                 is_immediate;
   logic [1:0]           branch_type;
   logic                 out_valid;
   logic                 illegal_op;
   logic                 front_stall;
   logic [CNT_W-1:0]     issue_count;
   logic [CNT_W-1:0]     bubble_count;

   modport master (
      output opcode_in, in_valid, hazard_stall, flush,
      input  exe_cmd, mem_read, mem_write, wb_en, is_immediate, branch_type,
             out_valid, illegal_op, front_stall, issue_count, bubble_count
   );

   modport slave (
      input  opcode_in, in_valid, hazard_stall, flush,
      output exe_cmd, mem_read, mem_write, wb_en, is_immediate, branch_type,
             out_valid, illegal_op, front_stall, issue_count, bubble_count
   );
endinterface

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decodes opcodes into a registered ID/EX control word, inserts
// bubbles on stall/flush, sequences multi-cycle MUL and keeps issue/bubble counters.
//
// state   | meaning
// IDLE    | decoding one opcode per cycle
// MC_BUSY | multi-cycle MUL in flight; front end frozen, bubbles issued
module pipelined_control_unit #(
   parameter int                    OPCODE_W   = 6,
   parameter int                    EXE_CMD_W  = 4,
   parameter logic [OPCODE_W-1:0]   MUL_OPCODE = 6'd4,
   parameter int                    MC_LATENCY = 4,
   parameter int                    CNT_W      = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   pipelined_control_unit_if.slave     bus
);
   localparam int MC_CNT_W = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) + 1 : 1;

   typedef enum logic {IDLE, MC_BUSY} state_t;

   state_t               state_q;
   logic [MC_CNT_W-1:0]  mc_cnt_q;
   logic [EXE_CMD_W-1:0] exe_cmd_q;
   logic                 mem_read_q, mem_write_q, wb_en_q, is_immediate_q;
   logic [1:0]           branch_type_q;
   logic                 out_valid_q, illegal_op_q;
   logic [CNT_W-1:0]     issue_count_q, bubble_count_q;

   logic [EXE_CMD_W-1:0] exe_cmd_d;
   logic                 mem_read_d, mem_write_d, wb_en_d, is_immediate_d;
   logic [1:0]           branch_type_d;
   logic                 legal_d, nop_d, mul_d;

   always_comb begin
      exe_cmd_d      = '0;
      mem_read_d     = 1'b0;
      mem_write_d    = 1'b0;
      wb_en_d        = 1'b0;
      is_immediate_d = 1'b0;
      branch_type_d  = 2'b00;
      legal_d        = 1'b1;
      nop_d          = 1'b0;
      mul_d          = 1'b0;
      if (bus.opcode_in == MUL_OPCODE) begin
         exe_cmd_d = EXE_CMD_W'(4'b1011);
         wb_en_d   = 1'b1;
         mul_d     = 1'b1;
      end else begin
         case (bus.opcode_in)
            OPCODE_W'(0):  nop_d = 1'b1;
            OPCODE_W'(1):  begin exe_cmd_d = EXE_CMD_W'(4'b0000); wb_en_d = 1'b1; end
            OPCODE_W'(3):  begin exe_cmd_d = EXE_CMD_W'(4'b0010); wb_en_d = 1'b1; end
            OPCODE_W'(5):  begin exe_cmd_d = EXE_CMD_W'(4'b0100); wb_en_d = 1'b1; end
            OPCODE_W'(6):  begin exe_cmd_d = EXE_CMD_W'(4'b0101); wb_en_d = 1'b1; end
            OPCODE_W'(7):  begin exe_cmd_d = EXE_CMD_W'(4'b0110); wb_en_d = 1'b1; end
            OPCODE_W'(8):  begin exe_cmd_d = EXE_CMD_W'(4'b0111); wb_en_d = 1'b1; end
            OPCODE_W'(9):  begin exe_cmd_d = EXE_CMD_W'(4'b1000); wb_en_d = 1'b1; end
            OPCODE_W'(10): begin exe_cmd_d = EXE_CMD_W'(4'b1000); wb_en_d = 1'b1; end
            OPCODE_W'(11): begin exe_cmd_d = EXE_CMD_W'(4'b1001); wb_en_d = 1'b1; end
            OPCODE_W'(12): begin exe_cmd_d = EXE_CMD_W'(4'b1010); wb_en_d = 1'b1; end
            OPCODE_W'(32): begin
               exe_cmd_d = EXE_CMD_W'(4'b0000); is_immediate_d = 1'b1; wb_en_d = 1'b1;
            end
            OPCODE_W'(33): begin
               exe_cmd_d = EXE_CMD_W'(4'b0010); is_immediate_d = 1'b1; wb_en_d = 1'b1;
            end
            OPCODE_W'(36): begin
               mem_read_d = 1'b1; is_immediate_d = 1'b1; wb_en_d = 1'b1;
            end
            OPCODE_W'(37): begin mem_write_d = 1'b1; is_immediate_d = 1'b1; end
            OPCODE_W'(40): begin branch_type_d = 2'b01; is_immediate_d = 1'b1; end
            OPCODE_W'(41): begin branch_type_d = 2'b10; is_immediate_d = 1'b1; end
            OPCODE_W'(42): begin branch_type_d = 2'b11; is_immediate_d = 1'b1; end
            default:       legal_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         mc_cnt_q       <= '0;
         exe_cmd_q      <= '0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         wb_en_q        <= 1'b0;
         is_immediate_q <= 1'b0;
         branch_type_q  <= 2'b00;
         out_valid_q    <= 1'b0;
         illegal_op_q   <= 1'b0;
         issue_count_q  <= '0;
         bubble_count_q <= '0;
      end else begin
         // The counters classify the cycle that is ending by what it presented.
         if (out_valid_q) issue_count_q  <= issue_count_q + 1'b1;
         else             bubble_count_q <= bubble_count_q + 1'b1;

         exe_cmd_q      <= '0;
         mem_read_q     <= 1'b0;
         mem_write_q    <= 1'b0;
         wb_en_q        <= 1'b0;
         is_immediate_q <= 1'b0;
         branch_type_q  <= 2'b00;
         out_valid_q    <= 1'b0;
         illegal_op_q   <= 1'b0;

         if (bus.flush) begin
            state_q  <= IDLE;
            mc_cnt_q <= '0;
         end else if (state_q == MC_BUSY) begin
            if (mc_cnt_q == MC_CNT_W'(1)) begin
               state_q  <= IDLE;
               mc_cnt_q <= '0;
            end else begin
               mc_cnt_q <= mc_cnt_q - 1'b1;
            end
         end else if (!bus.hazard_stall && bus.in_valid) begin
            if (!legal_d) begin
               illegal_op_q <= 1'b1;
            end else if (!nop_d) begin
               exe_cmd_q      <= exe_cmd_d;
               mem_read_q     <= mem_read_d;
               mem_write_q    <= mem_write_d;
               wb_en_q        <= wb_en_d;
               is_immediate_q <= is_immediate_d;
               branch_type_q  <= branch_type_d;
               out_valid_q    <= 1'b1;
               if (mul_d && (MC_LATENCY > 1)) begin
                  state_q  <= MC_BUSY;
                  mc_cnt_q <= MC_CNT_W'(MC_LATENCY - 1);
               end
            end
         end
      end
   end

   assign bus.exe_cmd      = exe_cmd_q;
   assign bus.mem_read     = mem_read_q;
   assign bus.mem_write    = mem_write_q;
   assign bus.wb_en        = wb_en_q;
   assign bus.is_immediate = is_immediate_q;
   assign bus.branch_type  = branch_type_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.illegal_op   = illegal_op_q;
   assign bus.front_stall  = (state_q == MC_BUSY);
   assign bus.issue_count  = issue_count_q;
   assign bus.bubble_count = bubble_count_q;
endmodule
